// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, on magnitudes with a final sign fix.
module mult_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [31:0] acc_q, sh_q, opd_q;
    logic        is_div_q, neg_q, sgn_a_q, div0_q;

    logic        accept, last;
    logic        sgn, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [32:0] add_sum, div_sh;
    logic        div_ge;
    logic [31:0] div_sub, acc_nx, sh_nx;
    logic [63:0] mul_res;
    logic [31:0] quo, rem, res_hi, res_lo;

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

    assign accept = start && (state_q != S_RUN);
    assign last   = (state_q == S_RUN) && (cnt_q == 5'(ITER - 1));

    always_comb begin
        sgn   = ~op[0];
        a_neg = sgn & A[31];
        b_neg = sgn & B[31];
        mag_a = neg32(A, a_neg);
        mag_b = neg32(B, b_neg);
    end

    // One iteration: multiply adds into the upper half and shifts right;
    // divide shifts the remainder left and subtracts when it fits.
    always_comb begin
        add_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : 33'd0);
        div_sh  = {acc_q, sh_q[31]};
        div_ge  = div_sh >= {1'b0, opd_q};
        div_sub = div_sh[31:0] - opd_q;
        if (is_div_q) begin
            acc_nx = div_ge ? div_sub : div_sh[31:0];
            sh_nx  = {sh_q[30:0], div_ge};
        end else begin
            acc_nx = add_sum[32:1];
            sh_nx  = {add_sum[0], sh_q[31:1]};
        end
        mul_res = neg64({acc_nx, sh_nx}, neg_q);
        quo     = div0_q ? 32'hFFFF_FFFF : neg32(sh_nx, neg_q);
        rem     = neg32(acc_nx, sgn_a_q);
        res_hi  = is_div_q ? rem : mul_res[63:32];
        res_lo  = is_div_q ? quo : mul_res[31:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + 5'd1;
        end
        if (last) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (state_q != S_RUN) begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Working registers carry no reset; they are fully loaded when an op is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q    <= '0;
            sh_q     <= op[1] ? mag_a : mag_b;
            opd_q    <= op[1] ? mag_b : mag_a;
            is_div_q <= op[1];
            neg_q    <= a_neg ^ b_neg;
            sgn_a_q  <= a_neg;
            div0_q   <= (B == 32'd0);
        end else if (state_q == S_RUN) begin
            acc_q <= acc_nx;
            sh_q  <= sh_nx;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, popped when done pulses.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] A, B, wdata;
    logic        busy, done;
    logic [31:0] HI, LO;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] pu;
        int          sq, sr;
        case (o)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                pu = {32'd0, a} * {32'd0, b};
                e.hi = pu[63:32];
                e.lo = pu[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'd0;
                    e.lo = 32'h8000_0000;
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    e.hi = sr;
                    e.lo = sq;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        exp_q.push_back(e);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = ~o;
        A     = $urandom;
        B     = $urandom;
    endtask

    // mode 1: re-pulse start mid-run; mode 2: attempt MTHI/MTLO mid-run
    task automatic wait_result(input string name, input int mode);
        exp_t        e;
        logic [31:0] h0, l0;
        int          bad;
        h0  = HI;
        l0  = LO;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (busy !== 1'b1 || done !== 1'b0 || HI !== h0 || LO !== l0) bad++;
            if (mode == 1 && k == 5) begin
                start = 1'b1;
                A     = 32'h1111_1111;
                B     = 32'd3;
                op    = 2'b01;
            end
            if (mode == 1 && k == 6) start = 1'b0;
            if (mode == 2 && k == 3) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'h0BAD_0BAD;
            end
            if (mode == 2 && k == 4) begin
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            tick();
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL %s_run: %0d cycles with busy/done/HI/LO wrong, required 0", name, bad);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: done=%b busy=%b, required done=1 busy=0 at t0+32", name, done, busy);
        end
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s_result: scoreboard empty, HI=%h LO=%h", name, HI, LO);
        end else begin
            e = exp_q.pop_front();
            if (HI !== e.hi || LO !== e.lo) begin
                fails++;
                $display("FAIL %s_result: HI=%h LO=%h, required HI=%h LO=%h", name, HI, LO, e.hi, e.lo);
            end
        end
    endtask

    task automatic quiet_window(input string name);
        int seen;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL %s: %0d cycles with busy/done set, required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        wdata = '0;
        #1 reset = 1'b0;
        #2;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
        tests++;
        if (HI !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h, required 0", HI); end
        tests++;
        if (LO !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h, required 0", LO); end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_vectors();
        issue(2'b00, 32'hFFFF_FFFF, 32'd7, '{32'hFFFF_FFFF, 32'hFFFF_FFF9});
        wait_result("mult_neg", 0);
        issue(2'b01, 32'hFFFF_FFFF, 32'd7, '{32'd6, 32'hFFFF_FFF9});
        wait_result("multu", 0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_result("div_neg", 0);
        issue(2'b11, 32'd7, 32'd2, '{32'd1, 32'd3});
        wait_result("divu", 0);
        issue(2'b11, 32'h1234, 32'd0, '{32'h1234, 32'hFFFF_FFFF});
        wait_result("divu_by_zero", 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, '{32'd0, 32'h8000_0000});
        wait_result("div_overflow", 0);
        issue(2'b10, 32'hFFFF_FFF0, 32'd0, '{32'hFFFF_FFF0, 32'hFFFF_FFFF});
        wait_result("div_by_zero_neg", 0);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int k = 0; k < 10; k++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (k % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if (k % 4 == 1) b = -b;
            issue(o, a, b, model(o, a, b));
            wait_result("random", 0);
        end
    endtask

    task automatic test_start_ignored();
        tick();
        issue(2'b01, 32'h0001_0000, 32'h0001_0000, model(2'b01, 32'h0001_0000, 32'h0001_0000));
        wait_result("start_ignored", 1);
        tick();
        quiet_window("start_ignored_no_second");
    endtask

    task automatic test_back_to_back();
        issue(2'b11, 32'd100, 32'd7, model(2'b11, 32'd100, 32'd7));
        wait_result("b2b_first", 0);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5, model(2'b00, 32'hFFFF_FFFD, 32'd5));
        wait_result("b2b_second", 0);
        tick();
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL b2b_pulse: done=%b, required 0", done); end
    endtask

    task automatic test_mid_reset();
        issue(2'b00, 32'h1234, 32'h5678, model(2'b00, 32'h1234, 32'h5678));
        repeat (9) tick();
        #2 reset = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        tests++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            fails++;
            $display("FAIL midreset_hilo: HI=%h LO=%h, required 0/0", HI, LO);
        end
        tick();
        reset = 1'b1;
        exp_q.delete();
        quiet_window("midreset_no_done");
        issue(2'b10, 32'd100, 32'hFFFF_FFF9, model(2'b10, 32'd100, 32'hFFFF_FFF9));
        wait_result("after_reset", 0);
        tick();
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] l_prev;
        l_prev = LO;
        hi_we  = 1'b1;
        wdata  = 32'h0000_CAFE;
        tick();
        hi_we  = 1'b0;
        tests++;
        if (HI !== 32'h0000_CAFE || LO !== l_prev) begin
            fails++;
            $display("FAIL mthi_idle: HI=%h LO=%h, required HI=0000cafe LO=%h", HI, LO, l_prev);
        end
        lo_we = 1'b1;
        wdata = 32'h0000_FACE;
        tick();
        lo_we = 1'b0;
        tests++;
        if (LO !== 32'h0000_FACE) begin fails++; $display("FAIL mtlo_idle: LO=%h, required 0000face", LO); end
        lo_we = 1'b1;
        wdata = 32'h5555_5555;
        issue(2'b01, 32'd6, 32'd7, model(2'b01, 32'd6, 32'd7));
        lo_we = 1'b0;
        tests++;
        if (LO !== 32'h5555_5555) begin fails++; $display("FAIL mtlo_with_start: LO=%h, required 55555555", LO); end
        wait_result("mt_during_run", 2);
        hi_we = 1'b1;
        wdata = 32'hBEEF_0001;
        tick();
        hi_we = 1'b0;
        tests++;
        if (HI !== 32'hBEEF_0001 || LO !== 32'd42 || done !== 1'b0) begin
            fails++;
            $display("FAIL mthi_done_override: HI=%h LO=%h done=%b, required beef0001/0000002a/0", HI, LO, done);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_mid_reset();
        test_mthi_mtlo();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
